interrupt_context_unit: RTL and testbench
=========================================

// Module: interrupt_context_unit
// PURPOSE
//  Producer/consumer end around interrupt_controller. Latches raw cause events into a sticky cause vector (ca_o) for the controller.
//  Owns SR, takes jisr/il/mca back from the controller, saves context (EPC/ESR/ECA/EIL), masks SR and vectors the PC.
//  On eret, restores SR and returns to EPC. Sits between interrupt sources, interrupt_controller and the PC/SPR datapath.
// PARAMETERS
//  N_CAUSE    23            number of cause lines (ca/mca width)
//  ISR_BASE   32'h0000_0100 handler vector base address
//  VEC_SHIFT  5             vector stride = 1<<VEC_SHIFT bytes per level
//  SR_RESET   32'h0000_0000 SR value after reset
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous reset, active low
//  ev_i        in   N_CAUSE  one-cycle event pulses from sources
//  ca_o        out  N_CAUSE  registered sticky cause vector to interrupt_controller
//  sr_o        out  32       status register (mask) to interrupt_controller
//  mca_i       in   N_CAUSE  masked cause from interrupt_controller
//  jisr_i      in   1        interrupt request from interrupt_controller
//  il_i        in   5        serviced level from interrupt_controller
//  eret_i      in   1        return-from-exception strobe
//  pc_i        in   32       PC of interrupted instruction
//  sr_we_i     in   1        software SR write enable
//  sr_wdata_i  in   32       software SR write data
//  pc_load_o   out  1        one-cycle strobe: PC <= pc_next_o
//  pc_next_o   out  32       PC redirect target
//  epc_o/esr_o out  32       saved PC / saved SR
//  eca_o       out  N_CAUSE  saved masked cause
//  eil_o       out  5        saved level
//  in_isr_o    out  1        high in VECTOR and HANDLER
// BEHAVIOUR
//  Reset: ca_o=0, sr_o=SR_RESET, epc/esr/eca/eil=0, pc_load_o=0, pc_next_o=0, in_isr_o=0, state=RUN.
//  Cause latch: ca_q <= (ca_q & ~clr) | ev_i; ev_i visible on ca_o one cycle later.
//   clr = onehot(il_i) on accepted jisr, else 0. Set beats clear when the same bit fires.
//   All other pending bits are kept.
//  FSM states: RUN, VECTOR, HANDLER, RETURN.
//   RUN: jisr_i=1 -> epc<=pc_i, esr<=sr_o, eca<=mca_i, eil<=il_i, sr<=0, clear ca bit il_i; go to VECTOR.
//   VECTOR (1 cycle): pc_load_o=1, pc_next_o = ISR_BASE + (eil<<VEC_SHIFT); go to HANDLER.
//   HANDLER: stay until eret_i. On eret_i: sr<=esr; go to RETURN.
//   RETURN (1 cycle): pc_load_o=1, pc_next_o=epc; go to RUN.
//  Exception latency: jisr_i sampled at edge N; pc_load_o high in cycle N+1.
//  eret latency: eret_i at edge N; pc_load_o high in cycle N+1; SR restored at edge N.
//  pc_load_o is a single-cycle pulse. pc_next_o holds its value outside load cycles.
//  jisr_i outside RUN is ignored; its cause stays pending (this covers unmaskable bits 16/17).
//  eret_i outside HANDLER is ignored.
//  sr_we_i writes sr in RUN and HANDLER. It is dropped when the same cycle has an accepted jisr_i or eret_i (jisr/eret win).
//  ESR captures SR before any same-cycle write.
//  il_i >= N_CAUSE on an accepted jisr: context is saved, no ca bit is cleared, vector is still computed.
//  rst_n asserted mid-ISR: immediate return to reset values. No PC load is issued.
// CONFIGURATION
//  INTCTX_COUNT_EN defined: adds output irq_count_o[31:0], reset 0.
//   +1 on each accepted jisr; wraps from 32'hFFFF_FFFF to 0.
//  INTCTX_COUNT_EN undefined: port and counter are absent. All other behaviour is identical.
// TESTING
//  1 Reset: hold rst_n=0 with ev_i=all ones -> ca_o=0, sr_o=SR_RESET, pc_load_o=0. Release -> ca_o=all ones next cycle.
//  2 Sticky latch: ev_i=23'h80 for 1 cycle -> ca_o=23'h80 held for >=10 cycles while jisr_i=0.
//  3 Service: sr_o=32'hFFFFFFFF, ca_o=23'h3, jisr_i=1, il_i=0, mca_i=23'h3, pc_i=32'h400
//     -> epc=32'h400, esr=32'hFFFFFFFF, eca=23'h3, sr_o=0, ca_o=23'h2.
//     -> next cycle pc_load_o=1, pc_next_o=32'h100.
//  4 Vector math: accepted jisr with il_i=21 -> pc_next_o=32'h100+21*32=32'h3A0.
//  5 Return: in HANDLER pulse eret_i -> sr_o=esr. Next cycle pc_load_o=1, pc_next_o=epc. Then state RUN, in_isr_o=0.
//  6 Collisions:
//     a) ev_i bit0 with accepted jisr il=0 -> bit0 stays set.
//     b) jisr_i in HANDLER -> ignored.
//     c) sr_we_i with eret_i -> SR=esr.
//     d) rst_n low in HANDLER -> all reset values.
//     e) with INTCTX_COUNT_EN, 3 services -> irq_count_o=3.

Source files
------------

// File: rtl/interrupt_context_unit.sv
// Interrupt context unit: sticky cause latch, SR ownership, context save and PC vectoring.
// Optional INTCTX_COUNT_EN adds irq_count_o, a free-running count of accepted interrupts.
module interrupt_context_unit #(
  parameter int          N_CAUSE   = 23,
  parameter logic [31:0] ISR_BASE  = 32'h0000_0100,
  parameter int          VEC_SHIFT = 5,
  parameter logic [31:0] SR_RESET  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CAUSE-1:0] ev_i,
  output logic [N_CAUSE-1:0] ca_o,
  output logic [31:0]        sr_o,
  input  logic [N_CAUSE-1:0] mca_i,
  input  logic               jisr_i,
  input  logic [4:0]         il_i,
  input  logic               eret_i,
  input  logic [31:0]        pc_i,
  input  logic               sr_we_i,
  input  logic [31:0]        sr_wdata_i,
  output logic               pc_load_o,
  output logic [31:0]        pc_next_o,
  output logic [31:0]        epc_o,
  output logic [31:0]        esr_o,
  output logic [N_CAUSE-1:0] eca_o,
  output logic [4:0]         eil_o,
  output logic               in_isr_o
`ifdef INTCTX_COUNT_EN
  ,
  output logic [31:0]        irq_count_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_VECTOR,
    ST_HANDLER,
    ST_RETURN
  } state_t;

  localparam logic [N_CAUSE-1:0] CA_ONE = N_CAUSE'(1);

  state_t             state_q, state_d;
  logic               take_jisr;
  logic               take_eret;
  logic               sr_wr;
  logic [N_CAUSE-1:0] clr;
  logic [31:0]        vec_addr;

  always_comb begin
    state_d   = state_q;
    take_jisr = 1'b0;
    take_eret = 1'b0;
    sr_wr     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (jisr_i) begin
          take_jisr = 1'b1;
          state_d   = ST_VECTOR;
        end else begin
          sr_wr = sr_we_i;
        end
      end
      ST_VECTOR: state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (eret_i) begin
          take_eret = 1'b1;
          state_d   = ST_RETURN;
        end else begin
          sr_wr = sr_we_i;
        end
      end
      ST_RETURN: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Out-of-range levels shift the one past the top bit, so nothing clears.
  always_comb begin
    clr = '0;
    if (take_jisr) clr = CA_ONE << il_i;
  end

  assign vec_addr = ISR_BASE + ({27'd0, il_i} << VEC_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ca_o      <= '0;
      sr_o      <= SR_RESET;
      epc_o     <= '0;
      esr_o     <= '0;
      eca_o     <= '0;
      eil_o     <= '0;
      pc_next_o <= '0;
    end else begin
      state_q <= state_d;
      ca_o    <= (ca_o & ~clr) | ev_i;
      if (take_jisr) begin
        epc_o     <= pc_i;
        esr_o     <= sr_o;
        eca_o     <= mca_i;
        eil_o     <= il_i;
        sr_o      <= '0;
        pc_next_o <= vec_addr;
      end else if (take_eret) begin
        sr_o      <= esr_o;
        pc_next_o <= epc_o;
      end else if (sr_wr) begin
        sr_o <= sr_wdata_i;
      end
    end
  end

  assign pc_load_o = (state_q == ST_VECTOR) || (state_q == ST_RETURN);
  assign in_isr_o  = (state_q == ST_VECTOR) || (state_q == ST_HANDLER);

`ifdef INTCTX_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         irq_count_o <= '0;
    else if (take_jisr) irq_count_o <= irq_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_interrupt_context_unit.sv
// Bench for interrupt_context_unit: PC-load scoreboard plus directed state checks.
// Expected redirect targets are queued at issue; a monitor pops them on pc_load_o.
module tb_interrupt_context_unit;

  localparam int N = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  ev;
  logic [N-1:0]  ca;
  logic [31:0]   sr;
  logic [N-1:0]  mca;
  logic          jisr;
  logic [4:0]    il;
  logic          eret;
  logic [31:0]   pc;
  logic          sr_we;
  logic [31:0]   sr_wdata;
  logic          pc_load;
  logic [31:0]   pc_next;
  logic [31:0]   epc;
  logic [31:0]   esr;
  logic [N-1:0]  eca;
  logic [4:0]    eil;
  logic          in_isr;
`ifdef INTCTX_COUNT_EN
  logic [31:0]   irq_count;
`endif

  int            vectors = 0;
  int            miscompares = 0;
  logic [31:0]   exp_q[$];

  always #5 clk = ~clk;

  interrupt_context_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_i       (ev),
    .ca_o       (ca),
    .sr_o       (sr),
    .mca_i      (mca),
    .jisr_i     (jisr),
    .il_i       (il),
    .eret_i     (eret),
    .pc_i       (pc),
    .sr_we_i    (sr_we),
    .sr_wdata_i (sr_wdata),
    .pc_load_o  (pc_load),
    .pc_next_o  (pc_next),
    .epc_o      (epc),
    .esr_o      (esr),
    .eca_o      (eca),
    .eil_o      (eil),
    .in_isr_o   (in_isr)
`ifdef INTCTX_COUNT_EN
    ,
    .irq_count_o(irq_count)
`endif
  );

  always @(negedge clk) begin
    if (rst_n && pc_load) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pc_load_unexpected: got pc_next=%h, required no load", pc_next);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc_next !== e) begin
          miscompares++;
          $display("FAIL pc_load_target: got %h, required %h", pc_next, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic service(input logic [4:0] lvl, input logic [N-1:0] m,
                         input logic [31:0] p, input logic [31:0] target);
    jisr = 1'b1;
    il   = lvl;
    mca  = m;
    pc   = p;
    exp_q.push_back(target);
    step();
    jisr = 1'b0;
  endtask

  task automatic do_eret(input logic [31:0] target);
    eret = 1'b1;
    exp_q.push_back(target);
    step();
    eret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ev = '1; mca = '0; jisr = 1'b0; il = '0;
    eret = 1'b0; pc = '0; sr_we = 1'b0; sr_wdata = '0;
    step();
    step();
    chk("reset_ca", 32'(ca), 32'h0);
    chk("reset_sr", sr, 32'h0);
    chk("reset_pc_load", 32'(pc_load), 32'h0);
    chk("reset_pc_next", pc_next, 32'h0);
    chk("reset_in_isr", 32'(in_isr), 32'h0);
    rst_n = 1'b1;
    step();
    ev = '0;
    chk("release_ca_ones", 32'(ca), 32'h007F_FFFF);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rereset_ca", 32'(ca), 32'h0);

    ev = 23'h80;
    step();
    ev = '0;
    for (int i = 0; i < 10; i++) begin
      chk("sticky_ca", 32'(ca), 32'h80);
      step();
    end

    sr_we = 1'b1; sr_wdata = 32'hFFFF_FFFF;
    step();
    sr_we = 1'b0;
    chk("sr_write_run", sr, 32'hFFFF_FFFF);
    ev = 23'h3;
    step();
    ev = '0;
    chk("ca_pending", 32'(ca), 32'h83);

    service(5'd0, 23'h3, 32'h400, 32'h100);
    chk("svc_epc", epc, 32'h400);
    chk("svc_esr", esr, 32'hFFFF_FFFF);
    chk("svc_eca", 32'(eca), 32'h3);
    chk("svc_eil", 32'(eil), 32'h0);
    chk("svc_sr_masked", sr, 32'h0);
    chk("svc_ca_cleared", 32'(ca), 32'h82);
    chk("vec_pc_load", 32'(pc_load), 32'h1);
    chk("vec_in_isr", 32'(in_isr), 32'h1);
    step();
    chk("hdl_pc_load", 32'(pc_load), 32'h0);
    chk("hdl_pc_next_hold", pc_next, 32'h100);
    chk("hdl_in_isr", 32'(in_isr), 32'h1);

    jisr = 1'b1; il = 5'd1; mca = 23'h2; pc = 32'h800;
    step();
    jisr = 1'b0;
    chk("hdl_jisr_epc", epc, 32'h400);
    chk("hdl_jisr_ca", 32'(ca), 32'h82);
    chk("hdl_jisr_eil", 32'(eil), 32'h0);
    sr_we = 1'b1; sr_wdata = 32'h55;
    step();
    sr_we = 1'b0;
    chk("sr_write_hdl", sr, 32'h55);

    sr_we = 1'b1; sr_wdata = 32'hAAAA;
    do_eret(32'h400);
    sr_we = 1'b0;
    chk("eret_sr_restore", sr, 32'hFFFF_FFFF);
    chk("ret_pc_load", 32'(pc_load), 32'h1);
    chk("ret_in_isr", 32'(in_isr), 32'h0);
    step();
    chk("run_pc_load", 32'(pc_load), 32'h0);
    chk("run_in_isr", 32'(in_isr), 32'h0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_in_run_ignored", 32'(pc_load), 32'h0);

    ev = 23'h1;
    step();
    chk("ca_bit0_set", 32'(ca), 32'h83);
    service(5'd0, 23'h1, 32'h500, 32'h100);
    ev = '0;
    chk("set_beats_clear", 32'(ca), 32'h83);
    step();
    do_eret(32'h500);
    step();

    service(5'd21, 23'h0, 32'h600, 32'h3A0);
    chk("lvl21_eil", 32'(eil), 32'd21);
    chk("lvl21_pc_next", pc_next, 32'h3A0);
    step();
    do_eret(32'h600);
    step();

    service(5'd25, 23'h0, 32'h700, 32'h420);
    chk("lvl25_ca_kept", 32'(ca), 32'h83);
    chk("lvl25_eil", 32'(eil), 32'd25);
    chk("lvl25_epc", epc, 32'h700);
    step();
`ifdef INTCTX_COUNT_EN
    chk("irq_count", irq_count, 32'd4);
`endif

    rst_n = 1'b0;
    #1;
    chk("midisr_rst_ca", 32'(ca), 32'h0);
    chk("midisr_rst_sr", sr, 32'h0);
    chk("midisr_rst_epc", epc, 32'h0);
    chk("midisr_rst_esr", esr, 32'h0);
    chk("midisr_rst_eca", 32'(eca), 32'h0);
    chk("midisr_rst_eil", 32'(eil), 32'h0);
    chk("midisr_rst_pc_next", pc_next, 32'h0);
    chk("midisr_rst_pc_load", 32'(pc_load), 32'h0);
    chk("midisr_rst_in_isr", 32'(in_isr), 32'h0);
`ifdef INTCTX_COUNT_EN
    chk("midisr_rst_count", irq_count, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
